div_ctrl: RTL
=============

Name: div_ctrl

Overview:
- Iterative radix-2 restoring divide sequencer for DIV/DIVU; sits in the EX stage beside the ALU and produces the 64-bit HI/LO result: HI = remainder, LO = quotient.
- Holds the pipeline with a stall request while iterating.
- Presents a registered hilores for one cycle with ready.
- Honours an annul (flush) from the exception logic.

Parameters:
- WIDTH, 32, operand width; hilores is 2*WIDTH; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  EX holds a DIV/DIVU; sampled only in IDLE
- signed_div  in  1  1 = DIV, 0 = DIVU; sampled with start
- srca  in  WIDTH  dividend
- srcb  in  WIDTH  divisor
- annul  in  1  flush; aborts any operation in progress
- stall_req  out  1  pipeline hold request
- busy  out  1  state is not IDLE
- ready  out  1  one-cycle result-valid strobe
- div_by_zero  out  1  valid with ready; divisor was zero
- hilores  out  2*WIDTH  {remainder, quotient}; registered

Behaviour:
- Reset (async): state=IDLE, counter=0, internal registers=0, hilores=0, ready=0, div_by_zero=0, busy=0.
- States: IDLE, ZERO (only when the optional feature is compiled in), BUSY, DONE.
- IDLE:
  - If start=1 and annul=0: latch |srca| and |srcb| (absolute values only when signed_div=1, otherwise raw).
  - Latch the quotient sign (srca[msb]^srcb[msb])&signed_div.
  - Latch the remainder sign srca[msb]&signed_div.
  - Latch the original srca and zero-flag (srcb==0), clear the partial remainder, counter=0, go to BUSY.
- BUSY:
  - One restoring step per cycle: shift {rem,quot} left 1, trial subtract divisor, keep if non-negative, and set the quotient LSB accordingly.
  - Counter increments each step; after step WIDTH-1 go to DONE, with hilores loaded at that same edge.
- Result formation at the transition into DONE:
  - Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set. Modulo 2^WIDTH: 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
  - If zero-flag is set, hilores={original srca, all-ones} regardless of signed_div, and div_by_zero=1.
- DONE: ready=1 for exactly one cycle, then unconditional return to IDLE. start is ignored in DONE, so a back-to-back divide begins next cycle.
- hilores holds its value until the next transition into DONE. ready and div_by_zero are 0 in every state except DONE.
- stall_req is combinational = (IDLE & start & ~annul) | BUSY | ZERO. It is low in DONE so the instruction advances while ready is high.
- Latency (WIDTH=32): start sampled at cycle 0, BUSY cycles 1..32, DONE/ready at cycle 33.
- busy = (state != IDLE).
- annul:
  - In any state: next state IDLE, no ready, hilores unchanged.
  - annul has priority over start in IDLE and over completion in BUSY.
  - annul in DONE: ready still asserted that cycle (already registered); the consumer gates it.
- Reset mid-operation: immediate return to reset values; no ready.

Optional Feature:
- Macro DIV_ZERO_FAST_EN.
- Defined: in IDLE a zero divisor goes to ZERO (1 cycle, stall_req=1), then DONE with the div-by-zero result; ready at cycle 2.
- Undefined: no ZERO state; zero divisors run the full WIDTH iterations and the result is overridden at DONE; ready at cycle 33.
- hilores and div_by_zero values are identical in both builds.

Test Plan:
- DIVU srca=100, srcb=7, start 1 cycle -> stall_req high cycles 0-32; ready at cycle 33 with hilores=0x00000002_0000000E, div_by_zero=0.
- DIV srca=0xFFFFFFF9 (-7), srcb=2 -> hilores=0xFFFFFFFF_FFFFFFFD (rem -1, quot -3).
- DIV srca=0x80000000, srcb=0xFFFFFFFF -> hilores=0x00000000_80000000; DIVU with the same operands -> 0x80000000_00000000.
- DIVU srca=0x12345678, srcb=0 -> hilores=0x12345678_FFFFFFFF and div_by_zero=1; ready at cycle 33 (macro off) or cycle 2 (macro on).
- Start DIVU 100/7, assert annul at cycle 10 -> IDLE at cycle 11, no ready, hilores keeps its prior value; a new start at cycle 12 completes normally at cycle 45.
- Assert rst at cycle 5 of an operation -> all outputs 0 immediately, busy=0; no ready follows.

Source files
------------

// File: rtl/div_ctrl_if.sv
// Handshake/bus bundle between the EX stage and the divide sequencer.
// master = EX-stage side, slave = div_ctrl.
interface div_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start;
    logic               signed_div;
    logic [WIDTH-1:0]   srca;
    logic [WIDTH-1:0]   srcb;
    logic               annul;
    logic               stall_req;
    logic               busy;
    logic               ready;
    logic               div_by_zero;
    logic [2*WIDTH-1:0] hilores;

    modport master (
        output start, signed_div, srca, srcb, annul,
        input  stall_req, busy, ready, div_by_zero, hilores
    );

    modport slave (
        input  start, signed_div, srca, srcb, annul,
        output stall_req, busy, ready, div_by_zero, hilores
    );
endinterface

// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider for DIV/DIVU, hilores = {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: zero divisors short-cut through a one-cycle
// ZERO state instead of running all WIDTH iterations.
module div_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus
);
    localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef DIV_ZERO_FAST_EN
        ZERO = 2'd1,
`endif
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic [WIDTH-1:0]   srca_q;
    logic               qsign_q;
    logic               rsign_q;
    logic               zero_q;
    logic [2*WIDTH-1:0] hilores_q;
    logic               ready_q;
    logic               dbz_q;

    logic [WIDTH:0]     shift_d;
    logic [WIDTH:0]     trial_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quot_d;
    logic [WIDTH-1:0]   rem_res_d;
    logic [WIDTH-1:0]   quot_res_d;
    logic [WIDTH-1:0]   a_abs_d;
    logic [WIDTH-1:0]   b_abs_d;
    logic               op_go_d;

    // Operand magnitudes at issue; signs only matter for DIV.
    always_comb begin
        a_abs_d = (bus.signed_div && bus.srca[WIDTH-1]) ? -bus.srca : bus.srca;
        b_abs_d = (bus.signed_div && bus.srcb[WIDTH-1]) ? -bus.srcb : bus.srcb;
        op_go_d = bus.start && !bus.annul;
    end

    // One restoring step plus sign fix-up of the step's outcome.
    always_comb begin
        shift_d    = {rem_q, quot_q[WIDTH-1]};
        trial_d    = shift_d - {1'b0, dvsr_q};
        quot_d     = {quot_q[WIDTH-2:0], ~trial_d[WIDTH]};
        rem_d      = trial_d[WIDTH] ? shift_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
        quot_res_d = qsign_q ? -quot_d : quot_d;
        rem_res_d  = rsign_q ? -rem_d : rem_d;
    end

    // Sequencer state, datapath registers and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            dvsr_q    <= '0;
            srca_q    <= '0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            zero_q    <= 1'b0;
            hilores_q <= '0;
            ready_q   <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            dbz_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (op_go_d) begin
                        rem_q   <= '0;
                        quot_q  <= a_abs_d;
                        dvsr_q  <= b_abs_d;
                        srca_q  <= bus.srca;
                        qsign_q <= (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]) & bus.signed_div;
                        rsign_q <= bus.srca[WIDTH-1] & bus.signed_div;
                        zero_q  <= (bus.srcb == '0);
                        cnt_q   <= '0;
`ifdef DIV_ZERO_FAST_EN
                        state_q <= (bus.srcb == '0) ? ZERO : BUSY;
`else
                        state_q <= BUSY;
`endif
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                ZERO: begin
                    if (bus.annul) begin
                        state_q <= IDLE;
                    end else begin
                        hilores_q <= {srca_q, {WIDTH{1'b1}}};
                        ready_q   <= 1'b1;
                        dbz_q     <= 1'b1;
                        state_q   <= DONE;
                    end
                end
`endif
                BUSY: begin
                    if (bus.annul) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                        cnt_q  <= cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            hilores_q <= zero_q ? {srca_q, {WIDTH{1'b1}}}
                                                : {rem_res_d, quot_res_d};
                            ready_q   <= 1'b1;
                            dbz_q     <= zero_q;
                            state_q   <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Hold the pipeline while an operation is being issued or iterated.
    always_comb begin
        bus.stall_req = (state_q == IDLE && op_go_d) || (state_q == BUSY);
`ifdef DIV_ZERO_FAST_EN
        if (state_q == ZERO) bus.stall_req = 1'b1;
`endif
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.ready       = ready_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hilores     = hilores_q;

endmodule
